// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data AXI4-Lite bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_RD_ADDR      = 3'd1,
    ST_RD_DATA      = 3'd2,
    ST_WR_ADDR_DATA = 3'd3,
    ST_WR_RESP      = 3'd4
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Any response other than OKAY is reported on bus_err.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_axi_wr_channel.sv
// AXI4-Lite write side: independent AW/W handshakes followed by the B wait.
module mem_bus_arbiter_axi_wr_channel (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic m_awready,
  input  logic m_wready,
  input  logic m_bvalid,
  output logic m_awvalid,
  output logic m_wvalid,
  output logic m_bready,
  output logic addr_data_done,
  output logic resp_done
);

  logic busy_q, busy_d;
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic bready_q, bready_d;
  logic aw_fin, w_fin;

  // Each valid drops once its own handshake has been seen.
  assign m_awvalid = busy_q & ~aw_done_q;
  assign m_wvalid  = busy_q & ~w_done_q;
  assign m_bready  = bready_q;

  // Track AW/W completion in any order and move on to the response wait.
  always_comb begin
    busy_d         = busy_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    bready_d       = bready_q;
    aw_fin         = aw_done_q | (m_awvalid & m_awready);
    w_fin          = w_done_q | (m_wvalid & m_wready);
    addr_data_done = busy_q & aw_fin & w_fin;
    resp_done      = bready_q & m_bvalid;

    if (start) begin
      busy_d    = 1'b1;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else if (addr_data_done) begin
      busy_d    = 1'b0;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      bready_d  = 1'b1;
    end else if (busy_q) begin
      aw_done_d = aw_fin;
      w_done_d  = w_fin;
    end

    if (resp_done) begin
      bready_d = 1'b0;
    end
  end

  // Handshake tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bready_q  <= bready_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the IF fetch port and the MEM load/store port onto one AXI4-Lite master.
//
// state           | meaning
// ST_IDLE         | no transaction; grant evaluated here (MEM beats IF)
// ST_RD_ADDR      | m_arvalid high, waiting for m_arready
// ST_RD_DATA      | m_rready high, waiting for m_rvalid
// ST_WR_ADDR_DATA | AW and W in flight, each completes independently
// ST_WR_RESP      | m_bready high, waiting for m_bvalid
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic [31:0]         if_rdata,
  output logic                if_valid,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_valid,
  output logic                bus_err,
  output logic                stallreq_if,
  output logic                stallreq_mem,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                if_valid_q, if_valid_d;
  logic                mem_valid_q, mem_valid_d;
  logic                bus_err_q, bus_err_d;
  logic                discard_q, discard_d;
  logic                flush_hit;
  logic                wr_start;
  logic                wr_addr_data_done;
  logic                wr_resp_done;

  mem_bus_arbiter_axi_wr_channel u_wr (
    .clk            (clk),
    .rst            (rst),
    .start          (wr_start),
    .m_awready      (m_awready),
    .m_wready       (m_wready),
    .m_bvalid       (m_bvalid),
    .m_awvalid      (m_awvalid),
    .m_wvalid       (m_wvalid),
    .m_bready       (m_bready),
    .addr_data_done (wr_addr_data_done),
    .resp_done      (wr_resp_done)
  );

  // Address/data outputs come straight from the grant-time latches, so they
  // cannot move while a valid is up.
  assign m_araddr     = addr_q;
  assign m_awaddr     = addr_q;
  assign m_wdata      = wdata_q;
  assign m_wstrb      = wstrb_q;
  assign m_arvalid    = (state_q == ST_RD_ADDR);
  assign m_rready     = (state_q == ST_RD_DATA);
  assign if_rdata     = if_rdata_q;
  assign if_valid     = if_valid_q;
  assign mem_rdata    = mem_rdata_q;
  assign mem_valid    = mem_valid_q;
  assign bus_err      = bus_err_q;
  assign stallreq_if  = if_req & ~if_valid_q;
  assign stallreq_mem = mem_req & ~mem_valid_q;

  // Next-state, grant and done-pulse generation.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_valid_d  = 1'b0;
    mem_valid_d = 1'b0;
    bus_err_d   = 1'b0;
    discard_d   = discard_q;
    wr_start    = 1'b0;

    // A flush in IDLE is ignored: the IF stage simply presents the new PC.
    flush_hit = if_flush & (owner_q == OWN_IF) & (state_q != ST_IDLE);
    if (flush_hit) begin
      discard_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (mem_req && !mem_valid_q) begin
          owner_d = OWN_MEM;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          if (mem_we) begin
            state_d  = ST_WR_ADDR_DATA;
            wr_start = 1'b1;
          end else begin
            state_d = ST_RD_ADDR;
          end
        end else if (if_req && !if_valid_q) begin
          owner_d = OWN_IF;
          addr_d  = if_addr;
          wdata_d = '0;
          wstrb_d = '0;
          state_d = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        if (m_arready) begin
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (m_rvalid) begin
          state_d   = ST_IDLE;
          discard_d = 1'b0;
          bus_err_d = resp_is_err(m_rresp);
          if (owner_q == OWN_MEM) begin
            mem_valid_d = 1'b1;
            mem_rdata_d = m_rdata;
          end else if (!(discard_q || flush_hit)) begin
            if_valid_d = 1'b1;
            if_rdata_d = addr_q[2] ? m_rdata[32 +: 32] : m_rdata[0 +: 32];
          end
        end
      end
      ST_WR_ADDR_DATA: begin
        if (wr_addr_data_done) begin
          state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (wr_resp_done) begin
          state_d     = ST_IDLE;
          mem_valid_d = 1'b1;
          bus_err_d   = resp_is_err(m_bresp);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched request and registered done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      bus_err_q   <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_valid_q  <= if_valid_d;
      mem_valid_q <= mem_valid_d;
      bus_err_q   <= bus_err_d;
      discard_q   <= discard_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with a behavioural AXI4-Lite slave.
module tb_mem_bus_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          if_valid;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [7:0]    mem_wstrb;
  logic [DW-1:0] mem_rdata;
  logic          mem_valid, bus_err, stallreq_if, stallreq_mem;
  logic [AW-1:0] m_araddr, m_awaddr;
  logic          m_arvalid, m_arready;
  logic [DW-1:0] m_rdata, m_wdata;
  logic [1:0]    m_rresp, m_bresp;
  logic          m_rvalid, m_rready, m_awvalid, m_awready;
  logic [7:0]    m_wstrb;
  logic          m_wvalid, m_wready, m_bvalid, m_bready;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .bus_err(bus_err),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  int n_vec = 0;
  int n_miscmp = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit          v_if;
    bit          v_mem;
    bit          err;
    bit          chk_data;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];

  // Slave configuration, sampled by the slave at the start of each transaction.
  int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [63:0] rd_base = '0;
  logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;
  logic [63:0] seen_awaddr, seen_wdata;
  logic [7:0]  seen_wstrb;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] slave_rdata(input logic [63:0] a);
    return rd_base + a;
  endfunction

  task automatic push_fetch(input logic [63:0] a);
    exp_t e;
    logic [63:0] d;
    d = slave_rdata(a);
    e.v_if = 1'b1; e.v_mem = 1'b0; e.err = 1'b0; e.chk_data = 1'b1;
    e.data = a[2] ? {32'h0, d[63:32]} : {32'h0, d[31:0]};
    sb.push_back(e);
  endtask

  task automatic push_load(input logic [63:0] a, input bit err);
    exp_t e;
    e.v_if = 1'b0; e.v_mem = 1'b1; e.err = err; e.chk_data = 1'b1;
    e.data = slave_rdata(a);
    sb.push_back(e);
  endtask

  task automatic push_store();
    exp_t e;
    e.v_if = 1'b0; e.v_mem = 1'b1; e.err = 1'b0; e.chk_data = 1'b0;
    e.data = '0;
    sb.push_back(e);
  endtask

  task automatic wait_if_done(input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (if_valid) break;
      n++;
    end
    if (n >= budget) chk("if_done_timeout", 64'd1, 64'd0);
    if_req = 1'b0;
  endtask

  task automatic wait_mem_done(input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (mem_valid) break;
      n++;
    end
    if (n >= budget) chk("mem_done_timeout", 64'd1, 64'd0);
    mem_req = 1'b0;
  endtask

  // Read slave: AR then R, with per-transaction waits.
  initial begin
    int n, aw_l, rw_l;
    logic [63:0] ra;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    forever begin
      tick();
      if (!rst && m_arvalid) begin
        ra = m_araddr; aw_l = ar_wait; rw_l = r_wait;
        for (int i = 0; i < aw_l && !rst; i++) tick();
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        for (int i = 0; i < rw_l && !rst; i++) tick();
        if (!rst) begin
          m_rvalid = 1'b1; m_rdata = slave_rdata(ra); m_rresp = rresp_cfg;
          n = 0;
          while (!m_rready && !rst && n < 50) begin tick(); n++; end
          tick();
          m_rvalid = 1'b0; m_rresp = 2'b00;
        end
      end
    end
  end

  // Write slave: AW and W accepted independently, then B.
  initial begin
    int n, ac, wc, bw;
    bit aw_ok, w_ok;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    forever begin
      tick();
      if (!rst && m_awvalid) begin
        aw_ok = 1'b0; w_ok = 1'b0; ac = aw_wait; wc = w_wait; bw = b_wait; n = 0;
        while (!(aw_ok && w_ok) && !rst && n < 50) begin
          m_awready = !aw_ok && (ac == 0);
          m_wready  = !w_ok && (wc == 0);
          if (m_awready) begin
            chk("awvalid_held", 64'(m_awvalid), 64'd1);
            seen_awaddr = m_awaddr;
          end
          if (m_wready) begin
            chk("wvalid_held", 64'(m_wvalid), 64'd1);
            seen_wdata = m_wdata; seen_wstrb = m_wstrb;
          end
          tick();
          n++;
          if (m_awready) aw_ok = 1'b1; else if (ac > 0) ac--;
          if (m_wready) w_ok = 1'b1; else if (wc > 0) wc--;
          m_awready = 1'b0; m_wready = 1'b0;
        end
        for (int i = 0; i < bw && !rst; i++) tick();
        if (!rst) begin
          m_bvalid = 1'b1; m_bresp = bresp_cfg;
          n = 0;
          while (!m_bready && !rst && n < 50) begin tick(); n++; end
          if (!rst) tick();
          m_bvalid = 1'b0; m_bresp = 2'b00;
        end
      end
    end
  end

  // Done-pulse monitor and read/write exclusivity check.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("axi_overlap", 64'((m_arvalid | m_rready) & (m_awvalid | m_wvalid | m_bready)), 64'd0);
        if (if_valid || mem_valid || bus_err) begin
          if (sb.size() == 0) begin
            chk("spurious_done", 64'({if_valid, mem_valid, bus_err}), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("if_valid", 64'(if_valid), 64'(e.v_if));
            chk("mem_valid", 64'(mem_valid), 64'(e.v_mem));
            chk("bus_err", 64'(bus_err), 64'(e.err));
            if (e.chk_data) chk("rdata", e.v_if ? {32'h0, if_rdata} : mem_rdata, e.data);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500us");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ctrl", 64'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, if_valid, mem_valid, bus_err}), 64'd0);
    chk("rst_if_rdata", 64'(if_rdata), 64'd0);
    chk("rst_mem_rdata", mem_rdata, 64'd0);
    chk("rst_araddr", m_araddr, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Zero-wait fetch of the upper word.
    rd_base = 64'h1111_2222_3333_4444 - 64'h0000_0000_8000_0004;
    push_fetch(64'h8000_0004);
    if_addr = 64'h8000_0004; if_req = 1'b1;
    @(negedge clk);
    chk("t1_c0_stall", 64'(stallreq_if), 64'd1);
    chk("t1_c0_arvalid", 64'(m_arvalid), 64'd0);
    @(negedge clk);
    chk("t1_c1_arvalid", 64'(m_arvalid), 64'd1);
    chk("t1_c1_araddr", m_araddr, 64'h8000_0004);
    chk("t1_c1_stall", 64'(stallreq_if), 64'd1);
    @(negedge clk);
    chk("t1_c2_rready", 64'(m_rready), 64'd1);
    chk("t1_c2_stall", 64'(stallreq_if), 64'd1);
    @(negedge clk);
    chk("t1_c3_if_valid", 64'(if_valid), 64'd1);
    chk("t1_c3_if_rdata", 64'(if_rdata), 64'h1111_2222);
    chk("t1_c3_stall", 64'(stallreq_if), 64'd0);
    if_req = 1'b0;
    repeat (2) tick();

    // Simultaneous requests: MEM first, then IF.
    rd_base = 64'h0123_4567_89AB_CDEF;
    push_load(64'h1000, 1'b0);
    push_fetch(64'h8000_0008);
    mem_we = 1'b0; mem_addr = 64'h1000; mem_req = 1'b1;
    if_addr = 64'h8000_0008; if_req = 1'b1;
    @(negedge clk);
    chk("t2_stall_mem", 64'(stallreq_mem), 64'd1);
    chk("t2_stall_if", 64'(stallreq_if), 64'd1);
    fork
      wait_mem_done(40);
      wait_if_done(40);
    join
    repeat (2) tick();

    // Store with W lagging AW by three cycles, then a zero-wait store.
    aw_wait = 0; w_wait = 3;
    push_store();
    mem_we = 1'b1; mem_addr = 64'h2000; mem_wdata = 64'hDEAD_BEEF_CAFE_F00D; mem_wstrb = 8'h0F;
    mem_req = 1'b1;
    wait_mem_done(40);
    chk("t3a_awaddr", seen_awaddr, 64'h2000);
    chk("t3a_wdata", seen_wdata, 64'hDEAD_BEEF_CAFE_F00D);
    chk("t3a_wstrb", 64'(seen_wstrb), 64'h0F);
    tick();
    aw_wait = 0; w_wait = 0;
    push_store();
    mem_addr = 64'h2008; mem_wdata = 64'h0BAD_F00D_1234_5678; mem_wstrb = 8'hF0;
    mem_req = 1'b1;
    wait_mem_done(40);
    chk("t3b_awaddr", seen_awaddr, 64'h2008);
    chk("t3b_wdata", seen_wdata, 64'h0BAD_F00D_1234_5678);
    chk("t3b_wstrb", 64'(seen_wstrb), 64'hF0);
    mem_we = 1'b0;
    repeat (2) tick();

    // Flush while waiting on rvalid; the redirected fetch must come back.
    rd_base = 64'hA5A5_0000_5A5A_0000;
    r_wait = 4;
    if_addr = 64'h8000_0040; if_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_rready && n < 20);
    chk("t4_reach_rd_data", 64'(m_rready), 64'd1);
    r_wait = 0;
    if_flush = 1'b1; if_addr = 64'h8000_0100;
    push_fetch(64'h8000_0100);
    @(negedge clk);
    if_flush = 1'b0;
    wait_if_done(60);
    repeat (2) tick();

    // Load with SLVERR.
    rresp_cfg = 2'b10;
    push_load(64'h3000, 1'b1);
    mem_we = 1'b0; mem_addr = 64'h3000; mem_req = 1'b1;
    wait_mem_done(40);
    rresp_cfg = 2'b00;
    @(negedge clk);
    chk("t5_idle", 64'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}), 64'd0);
    tick();

    // Reset during WR_RESP, then a normal fetch.
    b_wait = 6;
    mem_we = 1'b1; mem_addr = 64'h4000; mem_wdata = 64'h5555_AAAA_5555_AAAA; mem_wstrb = 8'hFF;
    mem_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_bready && n < 20);
    chk("t6_reach_wr_resp", 64'(m_bready), 64'd1);
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    chk("t6_rst_ctrl", 64'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, if_valid, mem_valid, bus_err}), 64'd0);
    chk("t6_rst_addr", m_awaddr, 64'd0);
    chk("t6_rst_wdata", m_wdata, 64'd0);
    chk("t6_rst_wstrb", 64'(m_wstrb), 64'd0);
    chk("t6_rst_if_rdata", 64'(if_rdata), 64'd0);
    chk("t6_rst_mem_rdata", mem_rdata, 64'd0);
    rst = 1'b0; b_wait = 0;
    repeat (2) tick();
    rd_base = 64'h7777_0000_3333_0000;
    push_fetch(64'h8000_0200);
    if_addr = 64'h8000_0200; if_req = 1'b1;
    wait_if_done(40);
    repeat (4) tick();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Single-master AXI4-Lite bus arbiter shared between the instruction-fetch port (driven by the PC/IF stage) and the data-memory port (MEM stage) of the 64-bit RISC-V pipeline. It serialises requests, runs one bus transaction at a time through an FSM, and returns data with a one-cycle done pulse. It raises per-port stall requests that feed the pipeline stall controller, which drives stall[5:0]. It drops the data of a fetch that is in flight when a branch flush arrives.

Parameters:
ADDR_W, 64, address width of both ports and the AXI address channels
DATA_W, 64, data width; WSTRB width is DATA_W/8

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
if_req  in  1  fetch request; held high until if_valid
if_addr  in  ADDR_W  fetch address (PC); sampled at grant
if_flush  in  1  branch taken: discard result of the current/pending fetch
if_rdata  out  32  fetched instruction: low/high word chosen by if_addr[2]
if_valid  out  1  one-cycle done pulse for fetch
mem_req  in  1  load/store request; held until mem_valid
mem_we  in  1  1=store, 0=load
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  store data
mem_wstrb  in  DATA_W/8  store byte strobes
mem_rdata  out  DATA_W  load data
mem_valid  out  1  one-cycle done pulse for load/store
bus_err  out  1  one-cycle pulse when RRESP/BRESP != OKAY
stallreq_if  out  1  = if_req & ~if_valid
stallreq_mem  out  1  = mem_req & ~mem_valid
m_araddr/m_arvalid/m_arready  out/out/in  ADDR_W/1/1  AXI read address channel
m_rdata/m_rresp/m_rvalid/m_rready  in/in/in/out  DATA_W/2/1/1  AXI read data channel
m_awaddr/m_awvalid/m_awready  out/out/in  ADDR_W/1/1  AXI write address channel
m_wdata/m_wstrb/m_wvalid/m_wready  out/out/out/in  DATA_W/DATA_W/8/1/1  AXI write data channel
m_bresp/m_bvalid/m_bready  in/in/out  2/1/1  AXI write response channel

Behaviour:
- Reset: state=IDLE. All AXI valid/ready outputs are 0. if_valid, mem_valid and bus_err are 0. Data outputs and the latched address/data are 0. The discard flag is 0. Reset mid-transaction aborts to IDLE; the slave is reset with the system.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP. A register owner ∈ {IF, MEM} records the granted port.
- Grant is evaluated in IDLE only. mem_req beats if_req, because MEM holds the older instruction. A port whose done pulse is high in the current cycle is not re-granted in that cycle.
- On grant, latch addr, wdata, wstrb and we.
  - Load or fetch: go to RD_ADDR with m_arvalid=1 on the next cycle.
  - Store: go to WR_ADDR_DATA with m_awvalid=1 and m_wvalid=1 together.
- RD_ADDR: hold m_arvalid until m_arready. Then go to RD_DATA and drive m_rready=1.
- RD_DATA: on m_rvalid & m_rready, register the data and go to IDLE. In the next cycle pulse if_valid or mem_valid with the registered data.
- WR_ADDR_DATA: separate aw_done and w_done flags. Deassert each valid after its handshake; AW and W may complete in either order or in the same cycle. When both are done, go to WR_RESP with m_bready=1.
- WR_RESP: on m_bvalid, go to IDLE and pulse mem_valid.
- Minimum latency with a zero-wait slave: request seen at cycle 0, arvalid at cycle 1, rvalid at cycle 2, done pulse at cycle 3.
- Fetch flush:
  - if_flush while owner=IF and busy: set discard. The AXI transaction still completes (no abort). if_valid is suppressed and discard clears on return to IDLE.
  - if_flush in IDLE with if_req: no effect. The IF stage presents the new address.
- Errors: a non-OKAY response still completes the transaction and pulses the done signal. bus_err pulses in the same cycle as the done pulse, or alone if the fetch was discarded.
- The AXI address, data and strobe outputs stay stable while the corresponding valid is high.
- Done pulses are registered outputs. Stall requests are combinational from req and registered valid.

Decomposition:
- Shared package/define file: FSM state encodings, AXI RESP_OKAY=2'b00, owner encodings, ZERO constants reusing the existing define.v conventions.
- Optional sub-module axi_wr_channel: AW/W independent-handshake tracking plus B wait, instantiated once.

Test Plan:
- Zero-wait fetch: if_req=1, if_addr=0x80000004, slave returns 0x1111_2222_3333_4444 -> arvalid at cycle 1; if_valid at cycle 3 with if_rdata=0x11112222 (upper word); stallreq_if high cycles 0–2.
- Simultaneous if_req and mem_req (load 0x1000) -> MEM is granted first, then IF. Exactly one mem_valid and one if_valid, in that order, with no AXI overlap.
- Store with AW ready 3 cycles before W ready, then a second store with both ready in the same cycle -> both complete. mem_valid pulses once after bvalid; wstrb=0x0F is seen on the bus.
- Flush during RD_DATA with 4 wait cycles on rvalid -> transaction completes and if_valid stays 0. The next request (new PC 0x80000100) is fetched normally.
- Slave returns RRESP=2'b10 on a load -> mem_valid and bus_err pulse together; the FSM returns to IDLE.
- rst asserted in WR_RESP -> all outputs are 0 on the next cycle and state=IDLE. A later fetch works.
